// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: store-side enables/replication/alignment check and
// load-side lane select with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  stFunct3,
  input  logic [1:0]  stOff,
  input  logic [31:0] storeData,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned,
  input  logic [2:0]  ldFunct3,
  input  logic [1:0]  ldOff,
  input  logic [31:0] rdata,
  output logic [31:0] ldWord
);

  logic [31:0] shifted;

  always_comb begin
    be         = 4'b0000;
    wdata      = storeData;
    misaligned = 1'b0;
    case (stFunct3)
      F3_B, F3_BU: begin
        be    = 4'b0001 << stOff;
        wdata = {4{storeData[7:0]}};
      end
      F3_H, F3_HU: begin
        be         = stOff[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{storeData[15:0]}};
        misaligned = stOff[0];
      end
      F3_W: begin
        be         = 4'b1111;
        misaligned = |stOff;
      end
      default: begin
        be = 4'b0000;
      end
    endcase
  end

  // Halfword offsets are always 0 or 2 here, so one shift serves both sizes.
  always_comb begin
    shifted = rdata >> {ldOff, 3'b000};
    case (ldFunct3)
      F3_B:    ldWord = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ldWord = {24'b0, shifted[7:0]};
      F3_H:    ldWord = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   ldWord = {16'b0, shifted[15:0]};
      F3_W:    ldWord = rdata;
      default: ldWord = 32'b0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: latches a legal access, runs one req/ready bus transfer
// with a wait-cycle abort, and stalls the core until the DONE cycle.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  output logic [31:0] loadData,
  output logic        stall,
  output logic        lsuError,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [3:0]  memBe,
  output logic [31:0] memWdata,
  input  logic [31:0] memRdata,
  input  logic        memReady,
  output logic [1:0]  dbgState
);

  localparam int CW = $clog2(TIMEOUT + 1);

  // Handshake: memReq holds with stable latched bus fields from the first
  // BUS cycle until the cycle in which memReady is sampled high (or abort).
  state_t        state;
  logic [CW-1:0] waitCnt;
  logic          timedOut;
  logic [31:0]   addrQ;
  logic [31:0]   wdataQ;
  logic [3:0]    beQ;
  logic [2:0]    f3Q;
  logic          weQ;

  logic [3:0]    beNext;
  logic [31:0]   wdataNext;
  logic [31:0]   ldWord;
  logic          misaligned;
  logic          anyOp;
  logic          f3Ok;
  logic          legal;
  logic          onBus;

  lsu_align u_align (
    .stFunct3   (funct3),
    .stOff      (addr[1:0]),
    .storeData  (storeData),
    .be         (beNext),
    .wdata      (wdataNext),
    .misaligned (misaligned),
    .ldFunct3   (f3Q),
    .ldOff      (addrQ[1:0]),
    .rdata      (memRdata),
    .ldWord     (ldWord)
  );

  always_comb begin
    anyOp = memRead | memWrite;
    f3Ok  = memWrite ? (funct3 inside {F3_B, F3_H, F3_W})
                     : (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    legal = (memRead ^ memWrite) && f3Ok && !misaligned;
  end

  always_comb begin
    stall    = 1'b0;
    lsuError = 1'b0;
    case (state)
      IDLE: begin
        if (anyOp) begin
          stall    = legal;
          lsuError = !legal;
        end
      end
      BUS:     stall    = 1'b1;
      DONE:    lsuError = timedOut;
      default: stall    = 1'b0;
    endcase
  end

  assign onBus    = (state == BUS);
  assign memReq   = onBus;
  assign memWe    = onBus & weQ;
  assign memAddr  = onBus ? {addrQ[31:2], 2'b00} : 32'b0;
  assign memBe    = onBus ? beQ : 4'b0000;
  assign memWdata = (onBus && weQ) ? wdataQ : 32'b0;
  assign dbgState = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      waitCnt  <= '0;
      timedOut <= 1'b0;
      loadData <= 32'b0;
      addrQ    <= 32'b0;
      wdataQ   <= 32'b0;
      beQ      <= 4'b0000;
      f3Q      <= 3'b000;
      weQ      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (anyOp && legal) begin
            addrQ  <= addr;
            f3Q    <= funct3;
            weQ    <= memWrite;
            beQ    <= beNext;
            wdataQ <= wdataNext;
            state  <= BUS;
          end
        end
        BUS: begin
          if (memReady) begin
            if (!weQ) loadData <= ldWord;
            state <= DONE;
          end else if (waitCnt == CW'(TIMEOUT - 1)) begin
            timedOut <= 1'b1;
            if (!weQ) loadData <= 32'b0;
            state <= DONE;
          end else begin
            waitCnt <= waitCnt + CW'(1);
          end
        end
        DONE: begin
          waitCnt  <= '0;
          timedOut <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: reset state, loads/stores with wait states,
// illegal accesses, bus timeout and reset during an access.
module tb_lsu;
  import lsu_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] storeData;
  logic [31:0] loadData;
  logic        stall;
  logic        lsuError;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [3:0]  memBe;
  logic [31:0] memWdata;
  logic [31:0] memRdata;
  logic        memReady;
  logic [1:0]  dbgState;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_load = 32'b0;

  lsu #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .funct3    (funct3),
    .addr      (addr),
    .storeData (storeData),
    .loadData  (loadData),
    .stall     (stall),
    .lsuError  (lsuError),
    .memReq    (memReq),
    .memWe     (memWe),
    .memAddr   (memAddr),
    .memBe     (memBe),
    .memWdata  (memWdata),
    .memRdata  (memRdata),
    .memReady  (memReady),
    .dbgState  (dbgState)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    funct3    = 3'b000;
    addr      = 32'b0;
    storeData = 32'b0;
    memReady  = 1'b0;
    memRdata  = 32'b0;
  endtask

  // One legal access; waits < 0 means the slave never answers.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rdata, input int waits,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic [31:0] ld);
    int   nbus;
    logic exp_err;
    nbus    = (waits < 0) ? TO : waits + 1;
    exp_err = (waits < 0);
    if (rd) exp_q.push_back(ld);
    memRead = rd; memWrite = wr; funct3 = f3; addr = a; storeData = sd;
    @(negedge clk);
    check("idle_stall", 32'(stall), 32'd1);
    check("idle_err", 32'(lsuError), 32'd0);
    check("idle_req", 32'(memReq), 32'd0);
    for (int i = 0; i < nbus; i++) begin
      tick;
      addr      = ~a;
      storeData = ~sd;
      memReady  = (i == waits);
      memRdata  = (i == waits) ? rdata : 32'hA5A5_5A5A;
      @(negedge clk);
      check("bus_state", 32'(dbgState), 32'(BUS));
      check("bus_req", 32'(memReq), 32'd1);
      check("bus_addr", memAddr, {a[31:2], 2'b00});
      check("bus_be", 32'(memBe), 32'(be));
      check("bus_we", 32'(memWe), 32'(wr));
      check("bus_wdata", memWdata, wd);
      check("bus_stall", 32'(stall), 32'd1);
    end
    tick;
    idle_in;
    if (rd) last_load = exp_q.pop_front();
    @(negedge clk);
    check("done_state", 32'(dbgState), 32'(DONE));
    check("done_stall", 32'(stall), 32'd0);
    check("done_err", 32'(lsuError), 32'(exp_err));
    check("done_req", 32'(memReq), 32'd0);
    check("done_load", loadData, last_load);
    tick;
    check("back_idle", 32'(dbgState), 32'(IDLE));
  endtask

  task automatic illegal(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a);
    memRead = rd; memWrite = wr; funct3 = f3; addr = a; storeData = 32'h1111_2222;
    @(negedge clk);
    check("ill_err", 32'(lsuError), 32'd1);
    check("ill_stall", 32'(stall), 32'd0);
    check("ill_req", 32'(memReq), 32'd0);
    tick;
    idle_in;
    @(negedge clk);
    check("ill_state", 32'(dbgState), 32'(IDLE));
    check("ill_req2", 32'(memReq), 32'd0);
    check("ill_load", loadData, last_load);
    tick;
  endtask

  initial begin
    reset = 1'b1;
    idle_in;
    tick;
    tick;
    @(negedge clk);
    check("rst_state", 32'(dbgState), 32'(IDLE));
    check("rst_load", loadData, 32'h0);
    check("rst_req", 32'(memReq), 32'd0);
    check("rst_we", 32'(memWe), 32'd0);
    check("rst_addr", memAddr, 32'h0);
    check("rst_be", 32'(memBe), 32'd0);
    check("rst_wdata", memWdata, 32'h0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_err", 32'(lsuError), 32'd0);
    tick;
    reset = 1'b0;

    // loads: rd wr f3 addr sd rdata waits be wdata expected-load
    access(1, 0, F3_W,  32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 4'b1111, 32'h0, 32'hDEAD_BEEF);
    access(1, 0, F3_B,  32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 4'b1000, 32'h0, 32'hFFFF_FF80);
    access(1, 0, F3_BU, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 4'b1000, 32'h0, 32'h0000_0080);
    access(1, 0, F3_H,  32'h0000_1002, 32'h0, 32'h80FF_0000, 1, 4'b1100, 32'h0, 32'hFFFF_80FF);
    access(1, 0, F3_HU, 32'h0000_1000, 32'h0, 32'h1234_8001, 0, 4'b0011, 32'h0, 32'h0000_8001);
    access(1, 0, F3_B,  32'h0000_1001, 32'h0, 32'h0000_7F00, 2, 4'b0010, 32'h0, 32'h0000_007F);

    // stores leave loadData holding the last load
    access(0, 1, F3_H, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 3, 4'b1100, 32'hABCD_ABCD, 32'h0);
    access(0, 1, F3_B, 32'h0000_2001, 32'h0000_0055, 32'h0, 0, 4'b0010, 32'h5555_5555, 32'h0);
    access(0, 1, F3_W, 32'h0000_2004, 32'hCAFE_F00D, 32'h0, 1, 4'b1111, 32'hCAFE_F00D, 32'h0);

    // misaligned / illegal
    illegal(1, 0, F3_W,   32'h0000_1002);
    illegal(0, 1, F3_H,   32'h0000_1001);
    illegal(1, 1, F3_W,   32'h0000_1000);
    illegal(1, 0, 3'b011, 32'h0000_1000);
    illegal(0, 1, F3_BU,  32'h0000_1000);

    // timeout on a load
    access(1, 0, F3_W, 32'h0000_3000, 32'h0, 32'h0, -1, 4'b1111, 32'h0, 32'h0);

    // reset during the second BUS cycle
    access(1, 0, F3_W, 32'h0000_1008, 32'h0, 32'h7777_8888, 0, 4'b1111, 32'h0, 32'h7777_8888);
    memRead = 1'b1; funct3 = F3_W; addr = 32'h0000_1000;
    @(negedge clk);
    tick;
    memReady = 1'b0;
    @(negedge clk);
    check("rm_bus1_req", 32'(memReq), 32'd1);
    tick;
    reset = 1'b1;
    @(negedge clk);
    check("rm_bus2_req", 32'(memReq), 32'd1);
    tick;
    reset = 1'b0;
    idle_in;
    @(negedge clk);
    check("rm_req", 32'(memReq), 32'd0);
    check("rm_stall", 32'(stall), 32'd0);
    check("rm_load", loadData, 32'h0);
    check("rm_state", 32'(dbgState), 32'(IDLE));
    last_load = 32'h0;
    tick;
    access(1, 0, F3_W, 32'h0000_1004, 32'h0, 32'h0BAD_F00D, 0, 4'b1111, 32'h0, 32'h0BAD_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
